liquid_mixer: RTL and testbench

LIQUID_MIXER -- requirements
Module: liquid_mixer

---
 rtl/liquid_mixer.sv | 132 +++++++++++++
 tb/tb_liquid_mixer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/liquid_mixer.sv
// liquid_mixer: two-liquid fill / mix / drain sequencer with a saturating
// load/up/down timer whose terminal flag paces the mix and drain phases.
// Optional emergency-stop state is built when LIQUID_MIXER_EMERGENCY_EN is
// defined; otherwise x10 is present on the port list but has no effect.
module liquid_mixer #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x0,
  input  logic             x1,
  input  logic             x2,
  input  logic             x10,
  output logic             y0,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic [WIDTH-1:0] counter,
  output logic             counter_done,
  input  logic             enable,
  input  logic             load,
  input  logic             direction,
  input  logic [WIDTH-1:0] load_value
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL_A = 3'd1,
    FILL_B = 3'd2,
    MIX    = 3'd3,
    DRAIN  = 3'd4
`ifdef LIQUID_MIXER_EMERGENCY_EN
    ,EMERG = 3'd5
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             done_q;
  logic             done_rise;
  logic             y0_q, y1_q, y2_q, y3_q;

`ifndef LIQUID_MIXER_EMERGENCY_EN
  // Without the emergency feature the stop button is deliberately ignored.
  logic unused_x10;
  assign unused_x10 = x10;
`endif

  // Terminal flag follows the current counting direction.
  always_comb begin
    counter_done = direction ? (counter_q == TERM_V) : (counter_q == '0);
  end

  assign done_rise = counter_done & ~done_q;

  // Counter next value: load beats enable; stop at the terminal and never wrap.
  always_comb begin
    counter_d = counter_q;
    if (load) begin
      counter_d = load_value;
    end else if (enable && !counter_done) begin
      if (direction) begin
        if (counter_q != MAX_V) counter_d = counter_q + 1'b1;
      end else begin
        counter_d = counter_q - 1'b1;
      end
    end
  end

  // Counter and the delayed terminal flag used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
      done_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      done_q    <= counter_done;
    end
  end

  // Sequencer next state; each fill sensor only matters in its own state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (x0)        state_d = FILL_A;
      FILL_A:  if (x1)        state_d = FILL_B;
      FILL_B:  if (x2)        state_d = MIX;
      MIX:     if (done_rise) state_d = DRAIN;
      DRAIN:   if (done_rise) state_d = IDLE;
`ifdef LIQUID_MIXER_EMERGENCY_EN
      EMERG:   if (!x10)      state_d = IDLE;
`endif
      default:                state_d = IDLE;
    endcase
`ifdef LIQUID_MIXER_EMERGENCY_EN
    if (x10) state_d = EMERG;
`endif
  end

  // State register with valve/motor outputs decoded from the next state so
  // they are registered yet appear together with the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y0_q    <= 1'b0;
      y1_q    <= 1'b0;
      y2_q    <= 1'b0;
      y3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y0_q    <= (state_d == FILL_A);
      y1_q    <= (state_d == FILL_B);
      y3_q    <= (state_d == MIX);
`ifdef LIQUID_MIXER_EMERGENCY_EN
      y2_q    <= (state_d == DRAIN) || (state_d == EMERG);
`else
      y2_q    <= (state_d == DRAIN);
`endif
    end
  end

  assign y0      = y0_q;
  assign y1      = y1_q;
  assign y2      = y2_q;
  assign y3      = y3_q;
  assign counter = counter_q;

endmodule

// File: tb/tb_liquid_mixer.sv
// tb_liquid_mixer: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the mixer and its timer.
module tb_liquid_mixer;

  localparam int TERM = 10;
  localparam int MAXC = 255;

  logic       clk = 1'b0;
  logic       rst, x0, x1, x2, x10;
  logic       y0, y1, y2, y3;
  logic [7:0] counter;
  logic       counter_done;
  logic       enable, load, direction;
  logic [7:0] load_value;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  liquid_mixer #(.WIDTH(8), .TERMINAL(TERM)) dut (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2), .x10(x10),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .counter(counter), .counter_done(counter_done),
    .enable(enable), .load(load), .direction(direction),
    .load_value(load_value)
  );

  // Model phases of the process, named after what the plant is doing.
  localparam int P_IDLE = 0, P_FILLA = 1, P_FILLB = 2, P_MIX = 3, P_DRAIN = 4, P_EMERG = 5;
  int m_phase = P_IDLE;
  int m_cnt   = 0;
  bit m_prev  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc_n, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    bit at_end, fresh;
    at_end = direction ? (m_cnt == TERM) : (m_cnt == 0);
    fresh  = at_end && !m_prev;
    if (rst) begin
      m_phase = P_IDLE; m_cnt = 0; m_prev = 0;
    end else begin
      case (m_phase)
        P_IDLE:  if (x0)    m_phase = P_FILLA;
        P_FILLA: if (x1)    m_phase = P_FILLB;
        P_FILLB: if (x2)    m_phase = P_MIX;
        P_MIX:   if (fresh) m_phase = P_DRAIN;
        P_DRAIN: if (fresh) m_phase = P_IDLE;
        P_EMERG: if (!x10)  m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
`ifdef LIQUID_MIXER_EMERGENCY_EN
      if (x10) m_phase = P_EMERG;
`endif
      if (load) m_cnt = load_value;
      else if (enable && !at_end) begin
        if (direction) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : m_cnt;
        else           m_cnt = m_cnt - 1;
      end
      m_prev = at_end;
    end
  endtask

  task automatic step();
    int exp_done;
    @(posedge clk);
    model_tick();
    #1;
    cyc_n++;
    exp_done = direction ? (m_cnt == TERM) : (m_cnt == 0);
    check("y0", y0, m_phase == P_FILLA);
    check("y1", y1, m_phase == P_FILLB);
    check("y2", y2, (m_phase == P_DRAIN) || (m_phase == P_EMERG));
    check("y3", y3, m_phase == P_MIX);
    check("counter", counter, m_cnt);
    check("counter_done", counter_done, exp_done);
    $display("cyc=%0d rst=%0b x=%0b%0b%0b%0b ld=%0b en=%0b dir=%0b lv=%0d | y=%0b%0b%0b%0b cnt=%0d done=%0b",
             cyc_n, rst, x0, x1, x2, x10, load, enable, direction, load_value,
             y0, y1, y2, y3, counter, counter_done);
  endtask

  task automatic cyc(input logic r, input logic a, input logic b, input logic c,
                     input logic e, input logic ld, input logic en, input logic dir,
                     input logic [7:0] lv);
    rst = r; x0 = a; x1 = b; x2 = c; x10 = e;
    load = ld; enable = en; direction = dir; load_value = lv;
    step();
  endtask

  initial begin
    rst = 1; x0 = 0; x1 = 0; x2 = 0; x10 = 0;
    load = 0; enable = 0; direction = 1; load_value = 0;

    // Reset held two cycles.
    cyc(1,0,0,0,0, 0,0,1,0);
    cyc(1,0,0,0,0, 0,0,1,0);

    // Start, low sensor, high sensor pulses walk through the fill states.
    cyc(0,1,1,0,0, 0,0,1,0);   // x0 and x1 together: FILL_A only
    cyc(0,0,0,0,0, 0,0,1,0);
    cyc(0,1,0,1,0, 0,0,1,0);   // x0/x2 ignored in FILL_A
    cyc(0,0,1,0,0, 0,0,1,0);
    cyc(0,0,0,1,0, 0,0,1,0);

    // Mix timer: load 0, count up to terminal, then drain.
    cyc(0,0,0,0,0, 1,0,1,0);
    for (int i = 0; i < 13; i++) cyc(0,0,0,0,0, 0,1,1,0);
    // Drain: done still high, needs a fresh edge after reload.
    for (int i = 0; i < 3; i++)  cyc(0,0,0,0,0, 0,1,1,0);
    cyc(0,0,0,0,0, 1,0,1,0);
    for (int i = 0; i < 13; i++) cyc(0,0,0,0,0, 0,1,1,0);

    // Down count from 3 saturating at 0.
    cyc(0,0,0,0,0, 1,0,0,3);
    for (int i = 0; i < 6; i++) cyc(0,0,0,0,0, 0,1,0,0);

    // Mid-operation reset aborts to idle.
    cyc(0,1,0,0,0, 0,0,1,0);
    cyc(0,0,1,0,0, 0,0,1,0);
    cyc(1,1,1,1,1, 1,1,1,7);
    cyc(0,0,0,0,0, 0,0,1,0);

`ifdef LIQUID_MIXER_EMERGENCY_EN
    // Emergency stop during mixing.
    cyc(0,1,0,0,0, 0,0,1,0);
    cyc(0,0,1,0,0, 0,0,1,0);
    cyc(0,0,0,1,0, 0,0,1,0);
    cyc(0,0,0,0,1, 0,0,1,0);
    cyc(0,0,0,0,1, 0,0,1,0);
    cyc(0,0,0,0,0, 0,0,1,0);
    cyc(0,0,0,0,0, 0,0,1,0);
`else
    // Stop button has no effect in this build.
    cyc(0,1,0,0,1, 0,0,1,0);
    cyc(0,0,0,0,1, 0,0,1,0);
    cyc(1,0,0,0,0, 0,0,1,0);
`endif

    // Randomized traffic biased so the sequence makes progress.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] lv;
      lv = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 31) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0,
          lv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
